sm_display_value_encoder: RTL

- Upstream feeder for the 3-digit multiplexed seven-segment driver.
- Accepts a 12-bit value on a load strobe and renders it as three 8-bit segment patterns, digit1 (leftmost) to digit3 (rightmost).
- Two render modes: 3-nibble hex, or decimal via a sequential shift-add-3 (double-dabble) BCD conversion.
- Outputs stay registered and stable between updates, so the downstream mux can sample them at any time.

---
 rtl/sm_display_value_encoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sm_display_value_encoder.sv
// ---------------------------------------------------------------------------
// sm_display_value_encoder
//
// Converts a 12-bit value into three active-low seven-segment glyphs for the
// 3-digit multiplexed display driver. Renders as 3 hex nibbles, or as decimal
// through a sequential shift-add-3 (double-dabble) BCD conversion. Decimal
// values above 999 render as three dashes. Digit outputs are registered and
// change only when a finished result is written, so the downstream mux can
// sample them at any time.
//
// Ports:
//   clkin    in   1   system clock, rising edge
//   reset    in   1   synchronous active-high reset
//   value    in  12   value to display, sampled when load is accepted
//   dec_mode in   1   0 = hex render, 1 = decimal render
//   dp       in   3   decimal-point enables, dp[2] -> digit1, dp[0] -> digit3
//   load     in   1   request strobe, accepted only while busy = 0
//   busy     out  1   conversion in progress
//   done     out  1   one-cycle pulse when new digits first appear
//   digit1   out  8   leftmost digit segments {dp,g,f,e,d,c,b,a}, active-low
//   digit2   out  8   middle digit segments
//   digit3   out  8   rightmost digit segments
// ---------------------------------------------------------------------------
module sm_display_value_encoder #(
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic [11:0] value,
    input  logic        dec_mode,
    input  logic [2:0]  dp,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [7:0]  digit1,
    output logic [7:0]  digit2,
    output logic [7:0]  digit3
);

    localparam logic [7:0] GlyphDash  = 8'hBF;
    localparam logic [7:0] GlyphBlank = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StEnc
    } state_e;

    state_e      r_state;
    logic [11:0] r_shift;   // latched value; shifted out MSB-first in decimal mode
    logic [11:0] r_bcd;     // {hundreds, tens, ones}
    logic [3:0]  r_cnt;
    logic        r_dec;
    logic        r_ovf;
    logic [2:0]  r_dp;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_d1;
    logic [7:0]  r_d2;
    logic [7:0]  r_d3;

    logic [11:0] w_bcd_adj;
    logic [11:0] w_bcd_next;
    logic [7:0]  w_g1;
    logic [7:0]  w_g2;
    logic [7:0]  w_g3;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // Add 3 to every nibble >= 5 before the shift so it carries correctly.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_next = {w_bcd_adj[10:0], r_shift[11]};
    end

    // Glyph selection for the ENC write; dp bit clears bit7 on any glyph.
    always_comb begin
        w_g1 = GlyphBlank;
        w_g2 = GlyphBlank;
        w_g3 = GlyphBlank;
        if (r_ovf) begin
            w_g1 = GlyphDash;
            w_g2 = GlyphDash;
            w_g3 = GlyphDash;
        end else if (r_dec) begin
            w_g1 = seg7(r_bcd[11:8]);
            w_g2 = seg7(r_bcd[7:4]);
            w_g3 = seg7(r_bcd[3:0]);
            if (LZ_BLANK && (r_bcd[11:8] == 4'd0)) begin
                w_g1 = GlyphBlank;
                if (r_bcd[7:4] == 4'd0) begin
                    w_g2 = GlyphBlank;
                end
            end
        end else begin
            w_g1 = seg7(r_shift[11:8]);
            w_g2 = seg7(r_shift[7:4]);
            w_g3 = seg7(r_shift[3:0]);
        end
        w_g1 = w_g1 & ~{r_dp[2], 7'b0};
        w_g2 = w_g2 & ~{r_dp[1], 7'b0};
        w_g3 = w_g3 & ~{r_dp[0], 7'b0};
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_dec   <= 1'b0;
            r_ovf   <= 1'b0;
            r_dp    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d1    <= GlyphBlank;
            r_d2    <= GlyphBlank;
            r_d3    <= GlyphBlank;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (load) begin
                        r_shift <= value;
                        r_dec   <= dec_mode;
                        r_dp    <= dp;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (dec_mode && (value > 12'd999)) begin
                            r_ovf   <= 1'b1;
                            r_state <= StEnc;
                        end else begin
                            r_ovf   <= 1'b0;
                            r_state <= dec_mode ? StShift : StEnc;
                        end
                    end
                end
                StShift: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= {r_shift[10:0], 1'b0};
                    r_cnt   <= r_cnt + 4'd1;
                    if (r_cnt == 4'd11) begin
                        r_state <= StEnc;
                    end
                end
                StEnc: begin
                    r_d1    <= w_g1;
                    r_d2    <= w_g2;
                    r_d3    <= w_g3;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign digit1 = r_d1;
    assign digit2 = r_d2;
    assign digit3 = r_d3;

endmodule
